sync_frame_tx: RTL

Serial frame transmitter feeding the 1101 sequence-detector link from the sending side. Accepts bytes over a valid/ready stream and serialises each frame as a 4-bit `1101` sync marker, then payload bytes MSB-first, then a 2-bit zero gap. It bit-stuffs the payload so that `1101` appears on the line only at frame starts. One bit is emitted per `bit_en` strobe.

---
 rtl/seqdet_pkg.sv | 12 +
 rtl/sync_frame_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seqdet_pkg.sv
// Shared definitions for the 1101 sync-marker link: marker pattern and transmitter states.
package seqdet_pkg;
  localparam logic [3:0] SYNC_PATTERN = 4'b1101;
  localparam int         SYNC_LEN     = 4;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    GAP
  } tx_state_t;
endpackage

// File: rtl/sync_frame_tx.sv
// Bit-stuffed frame serialiser: 1101 marker, MSB-first payload, zero gap. data_out registered, one bit per bit_en.
// Backpressure: in_ready low while the 1-entry holding register is full; the FSM stalls when bit_en is low.
import seqdet_pkg::*;

module sync_frame_tx #(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              data_out,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int CNT_MAX = (DATA_W > GAP_BITS) ?
                           ((DATA_W > SYNC_LEN) ? DATA_W : SYNC_LEN) :
                           ((GAP_BITS > SYNC_LEN) ? GAP_BITS : SYNC_LEN);
  localparam int CNT_W = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_BITS - 1);

  tx_state_t         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              cur_last, cur_last_n;
  logic [2:0]        hist, hist_n;
  logic              data_out_n;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;
  logic              hold_valid;
  logic              take_hold;
  logic              line_bit;
  logic [1:0]        pre_idx;

  assign in_ready = !hold_valid;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      cur_last   <= 1'b0;
      hist       <= 3'b000;
      data_out   <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shift    <= shift_n;
      cur_last <= cur_last_n;
      hist     <= hist_n;
      data_out <= data_out_n;
      // Load and consume are mutually exclusive: load needs the register empty, consume needs it full.
      if (in_valid && in_ready) begin
        hold_data  <= in_data;
        hold_last  <= in_last;
        hold_valid <= 1'b1;
      end else if (take_hold) begin
        hold_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shift_n    = shift;
    cur_last_n = cur_last;
    hist_n     = hist;
    data_out_n = data_out;
    take_hold  = 1'b0;
    frame_done = 1'b0;
    underrun   = 1'b0;
    line_bit   = 1'b0;
    pre_idx    = 2'(SYNC_LEN - 1) - 2'(cnt);

    case (state)
      IDLE: begin
        if (hold_valid) begin
          shift_n    = hold_data;
          cur_last_n = hold_last;
          take_hold  = 1'b1;
          cnt_n      = '0;
          state_n    = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (bit_en) begin
          line_bit = SYNC_PATTERN[pre_idx];
          if (cnt == PRE_LAST) begin
            cnt_n   = PAY_LAST;
            state_n = PAYLOAD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      PAYLOAD: begin
        // A 0 after every 110 keeps 1101 off the line except at the marker.
        if (bit_en && hist != 3'b110) begin
          line_bit = shift[DATA_W-1];
          shift_n  = {shift[DATA_W-2:0], 1'b0};
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else if (cur_last) begin
            cnt_n   = GAP_LAST;
            state_n = GAP;
          end else if (hold_valid) begin
            shift_n    = hold_data;
            cur_last_n = hold_last;
            take_hold  = 1'b1;
            cnt_n      = PAY_LAST;
          end else begin
            underrun = 1'b1;
            cnt_n    = GAP_LAST;
            state_n  = GAP;
          end
        end
      end
      GAP: begin
        if (bit_en) begin
          if (cnt == '0) begin
            frame_done = 1'b1;
            state_n    = IDLE;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (bit_en) begin
      data_out_n = line_bit;
      hist_n     = {hist[1:0], line_bit};
    end
  end

endmodule
